// File: rtl/exec_muldiv_control.sv
// Iterative multiply/divide unit for the execute stage.
// One radix-2 step per cycle: shift-add multiply or restoring divide
// on operand magnitudes, followed by a sign-fix cycle and a one-cycle
// DONE pulse. The pipeline is stalled from the start cycle through FIX.
module exec_muldiv_control #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic [1:0]            op_in,
    input  logic [DATA_WIDTH-1:0] data_a_in,
    input  logic [DATA_WIDTH-1:0] data_b_in,
    input  logic                  flush_in,
    output logic                  stall_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] lo_data_out,
    output logic [DATA_WIDTH-1:0] hi_data_out,
    output logic                  div_by_zero_out
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic [1:0]           op_q;
    logic                 sign_a;
    logic                 sign_b;
    // Multiplicand (multiply) or divisor (divide) magnitude
    logic [W-1:0]         opnd_q;
    // acc_hi: partial product high / remainder
    // acc_lo: multiplier shifting out / dividend shifting out, quotient in
    logic [W-1:0]         acc_hi;
    logic [W-1:0]         acc_lo;
    logic [CNT_WIDTH-1:0] cnt;

    // Architectural result registers
    logic [W-1:0]         hi_q;
    logic [W-1:0]         lo_q;
    logic                 dz_q;

    // ---------------------------------------------------------------
    // Input decode
    // ---------------------------------------------------------------
    logic         start_ok;
    logic         zero_div;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;

    // Accept a new op only from IDLE; a concurrent flush squashes it
    always_comb begin
        start_ok = (state == IDLE) && start_in && !flush_in;
        zero_div = op_in[1] && (data_b_in == '0);
        a_neg    = op_in[0] && data_a_in[W-1];
        b_neg    = op_in[0] && data_b_in[W-1];
        a_mag    = a_neg ? (-data_a_in) : data_a_in;
        b_mag    = b_neg ? (-data_b_in) : data_b_in;
    end

    // ---------------------------------------------------------------
    // Iteration step datapath
    // ---------------------------------------------------------------
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W-1:0] div_diff;
    logic         div_ge;

    // One shift-add or restoring-subtract step on the accumulator pair
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[W-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // Remainder always stays below the divisor, so the low W bits
        // of the difference are exact whenever div_ge is set.
        div_diff  = div_shift[W-1:0] - opnd_q;
    end

    // ---------------------------------------------------------------
    // Sign correction applied in FIX
    // ---------------------------------------------------------------
    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    // Restore signs: product negated on sign mismatch, quotient likewise,
    // remainder follows the dividend
    always_comb begin
        prod_neg = -{acc_hi, acc_lo};
        fix_hi   = acc_hi;
        fix_lo   = acc_lo;
        case (op_q)
            2'b01: if (sign_a ^ sign_b) {fix_hi, fix_lo} = prod_neg;
            2'b11: begin
                fix_lo = (sign_a ^ sign_b) ? (-acc_lo) : acc_lo;
                fix_hi = sign_a ? (-acc_hi) : acc_hi;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush aborts from any busy state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = zero_div ? DONE : RUN;
            RUN: begin
                if (flush_in)                       state_nxt = IDLE;
                else if (cnt == CNT_WIDTH'(W - 1))  state_nxt = FIX;
            end
            FIX:  state_nxt = flush_in ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; stall asserts combinationally on start
    always_comb begin
        stall_out = ((state == IDLE) && start_in) || (state == RUN) || (state == FIX);
        busy_out  = (state != IDLE);
        done_out  = (state == DONE);
    end

    // ---------------------------------------------------------------
    // Operand latch and iteration registers
    // ---------------------------------------------------------------

    // Latch operands on start, then advance one step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        op_q   <= op_in;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        cnt    <= '0;
                        acc_hi <= '0;
                        if (op_in[1]) begin
                            opnd_q <= b_mag;
                            acc_lo <= a_mag;
                        end else begin
                            opnd_q <= a_mag;
                            acc_lo <= b_mag;
                        end
                    end
                end
                RUN: begin
                    if (!flush_in) begin
                        cnt <= cnt + 1'b1;
                        if (op_q[1]) begin
                            acc_hi <= div_ge ? div_diff : div_shift[W-1:0];
                            acc_lo <= {acc_lo[W-2:0], div_ge};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: written on the edge into DONE so they are valid
    // while done_out is high, and held otherwise (including on flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else if (start_ok && zero_div) begin
            hi_q <= data_a_in;
            lo_q <= '1;
            dz_q <= 1'b1;
        end else if ((state == FIX) && !flush_in) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
            dz_q <= 1'b0;
        end
    end

    assign hi_data_out     = hi_q;
    assign lo_data_out     = lo_q;
    assign div_by_zero_out = dz_q;

endmodule

// File: tb/tb_exec_muldiv_control.sv
// Scoreboard bench for exec_muldiv_control: stimulus pushes expected
// results with their due cycle, a negedge monitor pops on done_out.
module tb_exec_muldiv_control;

    logic        clk;
    logic        rst_n;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] data_a_in;
    logic [31:0] data_b_in;
    logic        flush_in;
    logic        stall_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] lo_data_out;
    logic [31:0] hi_data_out;
    logic        div_by_zero_out;

    exec_muldiv_control #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_in        (start_in),
        .op_in           (op_in),
        .data_a_in       (data_a_in),
        .data_b_in       (data_b_in),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .lo_data_out     (lo_data_out),
        .hi_data_out     (hi_data_out),
        .div_by_zero_out (div_by_zero_out)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done_out=1 with no op outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_hi"},    hi_data_out, e.hi);
                chk({e.name, "_lo"},    lo_data_out, e.lo);
                chk({e.name, "_dz"},    {31'd0, div_by_zero_out}, {31'd0, e.dz});
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_stall"}, {31'd0, stall_out}, 32'd0);
            end
        end
    end

    // Drive a start pulse in the current cycle and record the expectation
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                         input int lat, input string nm, output int n);
        exp_t e;
        @(posedge clk); #1;
        start_in  = 1'b1;
        op_in     = op;
        data_a_in = a;
        data_b_in = b;
        n = cyc;
        e.hi = hi; e.lo = lo; e.dz = dz; e.cyc = n + lat; e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start_in = 1'b0;
            if (!busy_out) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy_out still 1 after 100 cycles", nm);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                          input int lat, input string nm);
        int n;
        issue(op, a, b, hi, lo, dz, lat, nm, n);
        wait_idle(nm);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        start_in  = 1'b0;
        op_in     = 2'b00;
        data_a_in = '0;
        data_b_in = '0;
        flush_in  = 1'b0;

        #1;
        chk("reset_stall", {31'd0, stall_out}, 32'd0);
        chk("reset_busy",  {31'd0, busy_out},  32'd0);
        chk("reset_done",  {31'd0, done_out},  32'd0);
        chk("reset_hi",    hi_data_out, 32'd0);
        chk("reset_lo",    lo_data_out, 32'd0);
        chk("reset_dz",    {31'd0, div_by_zero_out}, 32'd0);
        #11 rst_n = 1'b1;

        // MULTU max x max with per-cycle stall/busy profile
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, "multu_max", n);
        #1;
        chk("multu_max_stall_c0", {31'd0, stall_out}, 32'd1);
        chk("multu_max_busy_c0",  {31'd0, busy_out},  32'd0);
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            start_in = 1'b0;
            #1;
            chk($sformatf("multu_max_stall_c%0d", k), {31'd0, stall_out}, (k <= 33) ? 32'd1 : 32'd0);
            chk($sformatf("multu_max_busy_c%0d", k),  {31'd0, busy_out},  (k <= 34) ? 32'd1 : 32'd0);
        end

        run_op(2'b01, 32'hFFFF_FFFD, 32'd7,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, "mult_m3x7");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_m7d2");

        // DIVU 100/7 with a start presented mid-RUN that must be ignored
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "divu_100d7", n);
        repeat (5) begin @(posedge clk); #1; start_in = 1'b0; end
        start_in = 1'b1; op_in = 2'b00; data_a_in = 32'd9; data_b_in = 32'd9;
        wait_idle("divu_100d7");

        run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "divu_5d0");
        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, "multu_2x3");
        run_op(2'b11, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1, "div_m8d0");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, "div_minm1");
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, "div_7dm2");
        run_op(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 1'b0, 34, "mult_m5xm6");

        // Flush at cycle 10 of a MULT: no done, results held
        @(posedge clk); #1;
        start_in = 1'b1; op_in = 2'b01; data_a_in = 32'h1234; data_b_in = 32'd5;
        repeat (5) begin @(posedge clk); #1; start_in = 1'b0; end
        start_in = 1'b1; op_in = 2'b00; data_a_in = 32'd9; data_b_in = 32'd9;
        @(posedge clk); #1; start_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush_in = 1'b1;
        @(posedge clk); #1 flush_in = 1'b0;
        #1;
        chk("flush_busy", {31'd0, busy_out}, 32'd0);
        chk("flush_hi",   hi_data_out, 32'd0);
        chk("flush_lo",   lo_data_out, 32'd30);
        repeat (40) @(posedge clk);
        chk("flush_lo_later", lo_data_out, 32'd30);

        // Flush together with start in IDLE suppresses the op
        @(posedge clk); #1;
        start_in = 1'b1; flush_in = 1'b1; op_in = 2'b00; data_a_in = 32'd3; data_b_in = 32'd3;
        @(posedge clk); #1;
        start_in = 1'b0; flush_in = 1'b0;
        chk("idle_flush_busy", {31'd0, busy_out}, 32'd0);

        // Asynchronous reset at cycle 20 of a DIVU
        @(posedge clk); #1;
        start_in = 1'b1; op_in = 2'b10; data_a_in = 32'd1000; data_b_in = 32'd3;
        @(posedge clk); #1; start_in = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_mid_busy",  {31'd0, busy_out},  32'd0);
        chk("rst_mid_done",  {31'd0, done_out},  32'd0);
        chk("rst_mid_hi",    hi_data_out, 32'd0);
        chk("rst_mid_lo",    lo_data_out, 32'd0);
        chk("rst_mid_dz",    {31'd0, div_by_zero_out}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_after_busy", {31'd0, busy_out}, 32'd0);

        run_op(2'b00, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 34, "multu_4x5");

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_muldiv_control.md
EXEC_MULDIV_CONTROL -- requirements
Module: exec_muldiv_control

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width; even, >= 8.
REQ-002 Parameter CNT_WIDTH, default 6, iteration counter width; must hold DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_in  input  1  execute stage presents a mult/div op this cycle.
REQ-006 op_in  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed); sampled with start_in.
REQ-007 data_a_in  input  DATA_WIDTH  multiplicand / dividend (forwarded ALU A value).
REQ-008 data_b_in  input  DATA_WIDTH  multiplier / divisor (forwarded ALU B value).
REQ-009 flush_in  input  1  abort the in-flight op (branch/jump redirect).
REQ-010 stall_out  output  1  freeze IF/ID/EX pipeline registers.
REQ-011 busy_out  output  1  op in flight (state not IDLE).
REQ-012 done_out  output  1  one-cycle pulse; results valid.
REQ-013 lo_data_out  output  DATA_WIDTH  product low half / quotient.
REQ-014 hi_data_out  output  DATA_WIDTH  product high half / remainder.
REQ-015 div_by_zero_out  output  1  last completed op was a divide with data_b_in = 0.

Function
REQ-016 States SHALL be IDLE, RUN, FIX, DONE.
REQ-017 IDLE: start_in=1 latches op, operand magnitudes (two's-complement absolute value when signed op), sign flags, counter=0; next state RUN, or DONE if divide with divisor 0.
REQ-018 RUN: one radix-2 step per cycle (shift-add multiply; restoring divide: shift remainder left, subtract divisor, keep if non-negative, quotient bit = 1); counter increments; after DATA_WIDTH steps -> FIX.
REQ-019 FIX: signed multiply with differing operand signs negates the 2*DATA_WIDTH product; signed divide negates quotient if signs differ, remainder takes dividend sign; unsigned ops unchanged; -> DONE.
REQ-020 DONE: hi/lo registers updated, done_out=1 for exactly this cycle; -> IDLE.
REQ-021 Latency: start at cycle N -> done_out at cycle N+DATA_WIDTH+2 (34 for default); divide-by-zero -> done_out at N+1.
REQ-022 stall_out = (state IDLE and start_in) or state RUN or state FIX; low in DONE so the consuming instruction advances with results valid.
REQ-023 busy_out = state != IDLE.
REQ-024 start_in while busy_out=1 SHALL be ignored; no re-latch of operands.
REQ-025 Divide by zero: lo = all ones, hi = dividend as presented, div_by_zero_out=1; any other completed op clears div_by_zero_out.
REQ-026 Signed DIV of most-negative by -1: lo = 0x80000000, hi = 0 (no trap).
REQ-027 flush_in=1 in any non-IDLE state: next state IDLE, no done_out, hi/lo/div_by_zero_out keep previous values; flush_in in IDLE with start_in SHALL suppress the start.
REQ-028 hi_data_out/lo_data_out SHALL hold last completed result until the next DONE.

Reset
REQ-029 rst_n low: state IDLE, counter 0, stall_out=0, busy_out=0, done_out=0, hi/lo 0, div_by_zero_out=0, immediately and independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard the op; no done_out after release.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_out at cycle 34, hi=0xFFFFFFFE, lo=0x00000001; stall_out high cycles 0-33.
REQ-032 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-034 DIVU 5 / 0 -> done_out at cycle 1, lo=0xFFFFFFFF, hi=5, div_by_zero_out=1; following MULTU 2x3 clears it, lo=6.
REQ-035 flush_in at cycle 10 of MULT -> IDLE at cycle 11, no done_out, hi/lo unchanged; start_in at cycle 5 during RUN ignored.
REQ-036 rst_n low at cycle 20 of DIVU -> all outputs 0 asynchronously; no done_out after release.
